bitstream_integrator_n: RTL and testbench
=========================================

# bitstream_integrator_n

Multi-channel, parametrised successor to the single-channel bitstream integrator. It counts ones on CHANNELS parallel stochastic bitstreams over a capture window. The window is gated by `capture` and can also end after a fixed sample count. Each completed result is presented on a registered valid/ready output with per-channel saturation flags. It sits at the network's bitstream-to-binary boundary, feeding binary consumers that may stall.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent bitstream inputs.
- `COUNT_W`, 16: width of each channel count and of the window sample counter.
- `WINDOW`, 0: auto-terminate length in samples; 0 = window ends only on `capture` falling; must be < 2^COUNT_W.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous active-high reset.
- `x` input CHANNELS: one bitstream bit per channel.
- `capture` input 1: window gate; bits sampled on every edge where `capture`=1.
- `y` output CHANNELS*COUNT_W: result, channel i at bits [i*COUNT_W +: COUNT_W].
- `y_sat` output CHANNELS: channel count saturated during that window.
- `y_len` output COUNT_W: samples taken in that window, saturating.
- `y_valid` output 1: result held and valid.
- `y_ready` input 1: consumer accepts result when `y_valid`&&`y_ready`.
- `overrun` output 1: one-cycle pulse, unaccepted result overwritten.
- `busy` output 1: FSM in READING.

## Operation
- FSM states:
  - IDLE: accumulators held at 0.
  - READING: accumulating.
- IDLE, `capture`=1: sample `x` into accumulators, sample count=1, go to READING. If `WINDOW`=1, end the window at this same edge instead.
- READING, `capture`=1: add each `x[i]` to acc[i] and increment the sample count.
- End of window, then go to IDLE. The window ends on either of:
  - the edge where `capture`=0 in READING; no sample is taken on that edge.
  - the edge taking sample number `WINDOW` (`WINDOW`>0); that sample is included.
- At end of window, on the same edge:
  - load `y`, `y_sat`, `y_len` from accumulators including any bit sampled on that edge;
  - set `y_valid`=1;
  - clear accumulators, sample count and sat flags.
- Back-to-back windows: if `capture` stays high after a WINDOW termination, the next edge (IDLE, `capture`=1) starts a new window with no lost sample.
- Arithmetic: unsigned; acc[i] saturates at 2^COUNT_W-1 and sets sat[i]. `y_len` saturates identically.
- Handshake:
  - `y_valid` clears on the edge where `y_ready`=1, unless a new result loads on that same edge. In that case `y_valid` stays 1 with the new data and no overrun is raised.
  - New result while `y_valid`=1 and `y_ready`=0: the register is overwritten and `overrun` pulses for one cycle.
  - `y` is stable while `y_valid`=1 and no new result loads.
- `x` is ignored in IDLE when `capture`=0.

## Timing
- Reset values: `y`=0, `y_sat`=0, `y_len`=0, `y_valid`=0, `overrun`=0, `busy`=0; FSM IDLE; accumulators 0.
- `rst` mid-window: the window is discarded and the pending output is lost.
- Latency: `capture` high for cycles k..k+N-1 and low at k+N (`WINDOW`=0): `y_valid`=1 from cycle k+N+1. Result counts exactly the N sampled bits.
- `WINDOW`=W with `capture` held high: results appear every W cycles, first at cycle k+W.
- `busy`=1 in cycles k+1..k+N (registered state).
- `capture` pulse of one cycle gives N=1.
- `y_ready` may be held high permanently; every result is then valid for exactly one cycle.

## Configuration
- `INTEGRATOR_BIPOLAR_EN` defined: bipolar mode.
  - Each sampled bit adds +1 if `x[i]`=1 and −1 if 0.
  - acc/`y` are two's-complement signed COUNT_W.
  - Saturation at +2^(COUNT_W-1)-1 and −2^(COUNT_W-1), setting `y_sat[i]`.
  - `y_len` unchanged.
- Undefined: unipolar count of ones, as above.

## Test plan
- Unipolar, `capture` high 10 cycles, x[0]=1 every cycle, x[1]=1010101010, `y_ready`=1 -> one-cycle `y_valid` at k+11, ch0=10, ch1=5, `y_len`=10, `y_sat`=0.
- `WINDOW`=8, `capture` held high 24 cycles, x[0]=1 -> three results ch0=8 at k+8, k+16, k+24; no sample lost.
- COUNT_W=4, 20 ones on ch2 -> ch2=15, `y_sat[2]`=1, `y_len`=15, others unaffected.
- `y_ready`=0, two windows complete -> `overrun` pulses once at second load, `y` shows second result; `y_ready`=1 then clears `y_valid` next edge.
- `rst` asserted mid-window after 5 samples, then new 3-sample window of ones -> no output from first window; second result=3, all outputs 0 during reset.
- `INTEGRATOR_BIPOLAR_EN`, 8 samples with 2 ones on ch0 -> ch0=−4 (0xFFFC at COUNT_W=16); all ones with COUNT_W=4, 12 samples -> +7, `y_sat`=1.

Source files
------------

// File: rtl/bitstream_integrator_n.sv
// Multi-channel stochastic bitstream integrator: counts ones per channel over a capture window.
// Define INTEGRATOR_BIPOLAR_EN for signed +1/-1 accumulation instead of a unipolar count of ones.
module bitstream_integrator_n #(
  parameter int CHANNELS = 4,
  parameter int COUNT_W  = 16,
  parameter int WINDOW   = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS-1:0]         x,
  input  logic                        capture,
  output logic [CHANNELS*COUNT_W-1:0] y,
  output logic [CHANNELS-1:0]         y_sat,
  output logic [COUNT_W-1:0]          y_len,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        overrun,
  output logic                        busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] READING = 1'b1;

  localparam logic [COUNT_W-1:0] U_MAX   = '1;
  localparam logic [COUNT_W-1:0] WIN_CNT = COUNT_W'(WINDOW);
`ifdef INTEGRATOR_BIPOLAR_EN
  localparam logic [COUNT_W-1:0] S_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
  localparam logic [COUNT_W-1:0] S_MIN = {1'b1, {(COUNT_W-1){1'b0}}};
`endif

  logic [0:0]          state;
  logic [COUNT_W-1:0]  acc    [CHANNELS];
  logic [COUNT_W-1:0]  acc_nx [CHANNELS];
  logic [CHANNELS-1:0] sat, sat_nx;
  logic [COUNT_W-1:0]  len, len_nx;
  logic                end_win;

  // Next accumulator values include the bit sampled on this edge, so a
  // WINDOW-terminated result can be loaded straight from them.
  always_comb begin
    len_nx = len;
    sat_nx = sat;
    for (int i = 0; i < CHANNELS; i++) acc_nx[i] = acc[i];
    if (capture) begin
      if (len != U_MAX) len_nx = len + 1'b1;
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef INTEGRATOR_BIPOLAR_EN
        if (x[i]) begin
          if (acc[i] == S_MAX) sat_nx[i] = 1'b1;
          else acc_nx[i] = acc[i] + 1'b1;
        end else begin
          if (acc[i] == S_MIN) sat_nx[i] = 1'b1;
          else acc_nx[i] = acc[i] - 1'b1;
        end
`else
        if (x[i]) begin
          if (acc[i] == U_MAX) sat_nx[i] = 1'b1;
          else acc_nx[i] = acc[i] + 1'b1;
        end
`endif
      end
    end
    end_win = 1'b0;
    if (state == READING && !capture) end_win = 1'b1;
    if (WINDOW > 0 && capture && len_nx == WIN_CNT) end_win = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sat     <= '0;
      len     <= '0;
      y       <= '0;
      y_sat   <= '0;
      y_len   <= '0;
      y_valid <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) acc[i] <= '0;
    end else begin
      overrun <= 1'b0;
      if (end_win) begin
        state   <= IDLE;
        sat     <= '0;
        len     <= '0;
        y_sat   <= sat_nx;
        y_len   <= len_nx;
        y_valid <= 1'b1;
        // A result accepted on the same edge it is replaced is not an overrun.
        overrun <= y_valid && !y_ready;
        for (int i = 0; i < CHANNELS; i++) begin
          acc[i] <= '0;
          y[i*COUNT_W +: COUNT_W] <= acc_nx[i];
        end
      end else begin
        if (capture) state <= READING;
        sat <= sat_nx;
        len <= len_nx;
        for (int i = 0; i < CHANNELS; i++) acc[i] <= acc_nx[i];
        if (y_ready) y_valid <= 1'b0;
      end
    end
  end

  assign busy = (state == READING);

endmodule

// File: tb/tb_bitstream_integrator_n.sv
// Directed bench for bitstream_integrator_n: three instances cover the default,
// a narrow saturating variant and a WINDOW=8 auto-terminating variant.
module tb_bitstream_integrator_n;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] x;
  logic capture;
  logic y_ready;

  logic [63:0] ya;  logic [3:0] ya_sat; logic [15:0] ya_len; logic ya_valid, ya_ovr, ya_busy;
  logic [15:0] yb;  logic [3:0] yb_sat; logic [3:0]  yb_len; logic yb_valid, yb_ovr, yb_busy;
  logic [63:0] yc;  logic [3:0] yc_sat; logic [15:0] yc_len; logic yc_valid, yc_ovr, yc_busy;

  int total = 0;
  int bad = 0;

`ifdef INTEGRATOR_BIPOLAR_EN
  localparam logic [63:0] EXP_BASIC = {16'hFFF6, 16'hFFF6, 16'h0000, 16'h000A};
  localparam logic [15:0] EXP_SATY  = 16'h8788;
  localparam logic [3:0]  EXP_SATF  = 4'b1111;
  localparam logic [63:0] EXP_W2    = {16'h0008, 16'hFFF8, 16'h0008, 16'hFFFC};
  localparam logic [63:0] EXP_W3    = {16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFF};
  localparam logic [63:0] EXP_WIN   = {16'hFFF8, 16'hFFF8, 16'hFFF8, 16'h0008};
`else
  localparam logic [63:0] EXP_BASIC = {16'h0000, 16'h0000, 16'h0005, 16'h000A};
  localparam logic [15:0] EXP_SATY  = 16'h0F00;
  localparam logic [3:0]  EXP_SATF  = 4'b0100;
  localparam logic [63:0] EXP_W2    = {16'h0008, 16'h0000, 16'h0008, 16'h0002};
  localparam logic [63:0] EXP_W3    = {16'h0000, 16'h0000, 16'h0001, 16'h0000};
  localparam logic [63:0] EXP_WIN   = {16'h0000, 16'h0000, 16'h0000, 16'h0008};
`endif
  localparam logic [63:0] EXP_THREE = {16'h0003, 16'h0003, 16'h0003, 16'h0003};

  always #5 clk = ~clk;

  bitstream_integrator_n #(.CHANNELS(4), .COUNT_W(16), .WINDOW(0)) dut_a (
    .clk(clk), .rst(rst), .x(x), .capture(capture), .y(ya), .y_sat(ya_sat), .y_len(ya_len),
    .y_valid(ya_valid), .y_ready(y_ready), .overrun(ya_ovr), .busy(ya_busy));

  bitstream_integrator_n #(.CHANNELS(4), .COUNT_W(4), .WINDOW(0)) dut_b (
    .clk(clk), .rst(rst), .x(x), .capture(capture), .y(yb), .y_sat(yb_sat), .y_len(yb_len),
    .y_valid(yb_valid), .y_ready(y_ready), .overrun(yb_ovr), .busy(yb_busy));

  bitstream_integrator_n #(.CHANNELS(4), .COUNT_W(16), .WINDOW(8)) dut_c (
    .clk(clk), .rst(rst), .x(x), .capture(capture), .y(yc), .y_sat(yc_sat), .y_len(yc_len),
    .y_valid(yc_valid), .y_ready(y_ready), .overrun(yc_ovr), .busy(yc_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; capture = 1'b0; x = '0; y_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    tick();
    total++; if (ya !== 64'h0) begin bad++; $display("FAIL reset_y actual=%h required=0", ya); end
    total++; if (ya_sat !== 4'h0) begin bad++; $display("FAIL reset_sat actual=%h required=0", ya_sat); end
    total++; if (ya_len !== 16'h0) begin bad++; $display("FAIL reset_len actual=%h required=0", ya_len); end
    total++; if ({ya_valid, ya_ovr, ya_busy} !== 3'b000) begin bad++; $display("FAIL reset_flags actual=%b required=000", {ya_valid, ya_ovr, ya_busy}); end
    total++; if ({yb_valid, yc_valid} !== 2'b00) begin bad++; $display("FAIL reset_valid_bc actual=%b required=00", {yb_valid, yc_valid}); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [9:0] pat;
    do_reset();
    pat = 10'b1010101010;
    for (int i = 0; i < 10; i++) begin
      capture = 1'b1; x = {2'b00, pat[9-i], 1'b1};
      tick();
    end
    total++; if ({ya_valid, ya_busy} !== 2'b01) begin bad++; $display("FAIL basic_during actual=%b required=01", {ya_valid, ya_busy}); end
    capture = 1'b0; x = 4'b1111;
    tick();
    total++; if (ya_valid !== 1'b1) begin bad++; $display("FAIL basic_valid actual=%b required=1", ya_valid); end
    total++; if (ya !== EXP_BASIC) begin bad++; $display("FAIL basic_y actual=%h required=%h", ya, EXP_BASIC); end
    total++; if (ya_len !== 16'd10) begin bad++; $display("FAIL basic_len actual=%0d required=10", ya_len); end
    total++; if (ya_sat !== 4'h0) begin bad++; $display("FAIL basic_sat actual=%b required=0000", ya_sat); end
    total++; if (ya_busy !== 1'b0) begin bad++; $display("FAIL basic_busy actual=%b required=0", ya_busy); end
    tick();
    total++; if (ya_valid !== 1'b0) begin bad++; $display("FAIL basic_valid_clear actual=%b required=0", ya_valid); end
  endtask

  task automatic test_window();
    do_reset();
    for (int t = 1; t <= 24; t++) begin
      capture = 1'b1; x = 4'b0001;
      tick();
      if (t % 8 == 0) begin
        total++; if (yc_valid !== 1'b1) begin bad++; $display("FAIL win_valid t=%0d actual=%b required=1", t, yc_valid); end
        total++; if (yc !== EXP_WIN) begin bad++; $display("FAIL win_y t=%0d actual=%h required=%h", t, yc, EXP_WIN); end
        total++; if (yc_len !== 16'd8) begin bad++; $display("FAIL win_len t=%0d actual=%0d required=8", t, yc_len); end
      end else begin
        total++; if (yc_valid !== 1'b0) begin bad++; $display("FAIL win_idle t=%0d actual=%b required=0", t, yc_valid); end
      end
      if (t == 8) begin
        total++; if (yc_busy !== 1'b0) begin bad++; $display("FAIL win_busy_end actual=%b required=0", yc_busy); end
      end
      if (t == 9) begin
        total++; if (yc_busy !== 1'b1) begin bad++; $display("FAIL win_busy_restart actual=%b required=1", yc_busy); end
      end
    end
    capture = 1'b0;
    tick();
    total++; if (yc_valid !== 1'b0) begin bad++; $display("FAIL win_after actual=%b required=0", yc_valid); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      capture = 1'b1; x = 4'b0100;
      tick();
    end
    capture = 1'b0; x = '0;
    tick();
    total++; if (yb_valid !== 1'b1) begin bad++; $display("FAIL sat_valid actual=%b required=1", yb_valid); end
    total++; if (yb !== EXP_SATY) begin bad++; $display("FAIL sat_y actual=%h required=%h", yb, EXP_SATY); end
    total++; if (yb_sat !== EXP_SATF) begin bad++; $display("FAIL sat_flags actual=%b required=%b", yb_sat, EXP_SATF); end
    total++; if (yb_len !== 4'd15) begin bad++; $display("FAIL sat_len actual=%0d required=15", yb_len); end
  endtask

  task automatic test_overrun();
    do_reset();
    y_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      capture = 1'b1; x = 4'b1111;
      tick();
    end
    capture = 1'b0;
    tick();
    total++; if ({ya_valid, ya_ovr} !== 2'b10) begin bad++; $display("FAIL ovr_first actual=%b required=10", {ya_valid, ya_ovr}); end
    total++; if (ya !== EXP_THREE) begin bad++; $display("FAIL ovr_first_y actual=%h required=%h", ya, EXP_THREE); end
    for (int s = 0; s < 8; s++) begin
      capture = 1'b1; x = {1'b1, 1'b0, 1'b1, (s == 0 || s == 5)};
      tick();
    end
    capture = 1'b0; x = '0;
    tick();
    total++; if ({ya_valid, ya_ovr} !== 2'b11) begin bad++; $display("FAIL ovr_pulse actual=%b required=11", {ya_valid, ya_ovr}); end
    total++; if (ya !== EXP_W2) begin bad++; $display("FAIL ovr_second_y actual=%h required=%h", ya, EXP_W2); end
    total++; if (ya_len !== 16'd8) begin bad++; $display("FAIL ovr_second_len actual=%0d required=8", ya_len); end
    tick();
    total++; if ({ya_valid, ya_ovr} !== 2'b10) begin bad++; $display("FAIL ovr_one_cycle actual=%b required=10", {ya_valid, ya_ovr}); end
    total++; if (ya !== EXP_W2) begin bad++; $display("FAIL ovr_stable actual=%h required=%h", ya, EXP_W2); end
    // one-sample window whose load coincides with acceptance of the held result
    capture = 1'b1; x = 4'b0010;
    tick();
    capture = 1'b0; x = '0; y_ready = 1'b1;
    tick();
    total++; if ({ya_valid, ya_ovr} !== 2'b10) begin bad++; $display("FAIL b2b_accept actual=%b required=10", {ya_valid, ya_ovr}); end
    total++; if (ya !== EXP_W3) begin bad++; $display("FAIL b2b_y actual=%h required=%h", ya, EXP_W3); end
    total++; if (ya_len !== 16'd1) begin bad++; $display("FAIL b2b_len actual=%0d required=1", ya_len); end
    tick();
    total++; if (ya_valid !== 1'b0) begin bad++; $display("FAIL b2b_clear actual=%b required=0", ya_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    y_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      capture = 1'b1; x = 4'b1111;
      tick();
    end
    capture = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      capture = 1'b1; x = 4'b1111;
      tick();
    end
    rst = 1'b1;
    tick();
    total++; if ({ya_valid, ya_ovr, ya_busy} !== 3'b000) begin bad++; $display("FAIL rmid_flags actual=%b required=000", {ya_valid, ya_ovr, ya_busy}); end
    total++; if (ya !== 64'h0 || ya_len !== 16'h0) begin bad++; $display("FAIL rmid_data actual=%h/%h required=0", ya, ya_len); end
    rst = 1'b0; capture = 1'b0; y_ready = 1'b1;
    tick();
    total++; if (ya_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_output actual=%b required=0", ya_valid); end
    for (int i = 0; i < 3; i++) begin
      capture = 1'b1; x = 4'b1111;
      tick();
    end
    capture = 1'b0;
    tick();
    total++; if (ya_valid !== 1'b1) begin bad++; $display("FAIL rmid_valid actual=%b required=1", ya_valid); end
    total++; if (ya !== EXP_THREE) begin bad++; $display("FAIL rmid_y actual=%h required=%h", ya, EXP_THREE); end
    total++; if (ya_len !== 16'd3) begin bad++; $display("FAIL rmid_len actual=%0d required=3", ya_len); end
  endtask

  initial begin
    rst = 1'b1; capture = 1'b0; x = '0; y_ready = 1'b1;
    test_reset();
    test_basic();
    test_window();
    test_saturation();
    test_overrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
